// File: rtl/ehl_spram_apb4.sv
// Single-port RAM behind an APB4 slave: byte-strobed writes, non-power-of-two depth, decode errors on pslverr.
// Latency: writes/errors 2 cycles (setup + access), reads 2+RD_WAIT cycles; one transfer per 2+wait cycles back-to-back.
// Backpressure: pready held low for RD_WAIT access cycles on valid reads; a master dropping psel/penable early aborts the transfer.
//
// Ports: pclk/preset (sync, active-high) | paddr, psel, penable, pwrite, pstrb, pwdata in | pready, pslverr, prdata out
//        par_inj (in) exists only when EHL_SPRAM_APB4_PARITY_EN is defined: inverts stored parity of the bytes written.
// Optional feature macro: EHL_SPRAM_APB4_PARITY_EN (one even-parity bit per byte, mismatches reported on pslverr).
module ehl_spram_apb4 #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 16,
    parameter int RD_WAIT    = 0
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    output logic                    pready,
    output logic                    pslverr,
    output logic [DATA_WIDTH-1:0]   prdata
`ifdef EHL_SPRAM_APB4_PARITY_EN
    ,
    input  logic                    par_inj
`endif
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int IDXW  = ADDR_WIDTH - OFF;
    localparam int MW    = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              cnt_q;
    logic [MW-1:0]           idx_q;
    logic                    wr_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   rd_q;
    logic                    capture;
    logic                    complete;
    logic                    mem_we;
    logic                    par_err;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Address decode on the live bus; only sampled on the setup edge.
    logic [IDXW-1:0]         idx_in;
    logic                    dec_err;
    logic                    setup;

    assign idx_in  = paddr[ADDR_WIDTH-1:OFF];
    assign dec_err = (paddr[OFF-1:0] != '0) || (32'(idx_in) >= 32'(DEPTH));
    assign setup   = psel && !penable;

    // Next-state and outputs. Outputs depend only on registered state,
    // counter and read word, never on the live address/data bus.
    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        complete = 1'b0;
        pready   = 1'b0;
        pslverr  = 1'b0;
        prdata   = '0;
        case (state_q)
            IDLE: begin
                if (setup) begin
                    state_d = ACCESS;
                    capture = 1'b1;
                end
            end
            ACCESS: begin
                pready = (cnt_q == 3'd0);
                if (pready) begin
                    pslverr = err_q || (!wr_q && par_err);
                    if (!wr_q && !err_q) begin
                        prdata = rd_q;
                    end
                end
                if (!(psel && penable)) begin
                    state_d = IDLE;
                end else if (cnt_q == 3'd0) begin
                    state_d  = DONE;
                    complete = 1'b1;
                end
            end
            DONE: begin
                // The cycle after completion doubles as the next setup phase.
                if (setup) begin
                    state_d = ACCESS;
                    capture = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                idx_q <= idx_in[MW-1:0];
                wr_q  <= pwrite;
                err_q <= dec_err;
                cnt_q <= (!pwrite && !dec_err) ? 3'(RD_WAIT) : 3'd0;
            end else if (state_d != ACCESS) begin
                cnt_q <= 3'd0;
            end else if (cnt_q != 3'd0) begin
                cnt_q <= cnt_q - 3'd1;
            end
        end
    end

    // Reset inhibits the write so a transfer interrupted by preset leaves the array untouched.
    assign mem_we = complete && wr_q && !err_q && !preset;

    // Storage array: no reset, contents survive preset.
    always_ff @(posedge pclk) begin
        if (mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (pstrb[b]) begin
                    mem[idx_q][b*8 +: 8] <= pwdata[b*8 +: 8];
                end
            end
        end
    end

    // Read is issued at the setup edge so the word sits in a register for the whole pready cycle.
    // idx_in is below DEPTH whenever dec_err is clear, so the truncated index is in range.
    always_ff @(posedge pclk) begin
        if (preset) begin
            rd_q <= '0;
        end else if (capture && !pwrite && !dec_err) begin
            rd_q <= mem[idx_in[MW-1:0]];
        end
    end

`ifdef EHL_SPRAM_APB4_PARITY_EN
    logic [BYTES-1:0] par_mem [DEPTH];
    logic [BYTES-1:0] rd_par_q;
    logic [BYTES-1:0] rd_calc;

    always_ff @(posedge pclk) begin
        if (mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (pstrb[b]) begin
                    par_mem[idx_q][b] <= (^pwdata[b*8 +: 8]) ^ par_inj;
                end
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            rd_par_q <= '0;
        end else if (capture && !pwrite && !dec_err) begin
            rd_par_q <= par_mem[idx_in[MW-1:0]];
        end
    end

    always_comb begin
        rd_calc = '0;
        for (int b = 0; b < BYTES; b++) begin
            rd_calc[b] = ^rd_q[b*8 +: 8];
        end
    end

    assign par_err = |(rd_calc ^ rd_par_q);
`else
    assign par_err = 1'b0;
`endif

endmodule
